// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add multiplier and bit-serial shifter
// behind a START/BUSY/DONE handshake with registered result and status flags.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);
    localparam logic [3:0] OP_FWD = 4'd0, OP_ADD = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_MUL = 4'd4, OP_SUB = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                           OP_SRA = 4'd8, OP_ROR = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, SHIFT} state_t;

    state_t               state, state_nxt;
    logic [3:0]           sel_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [SHW-1:0]       cnt;

    logic [WIDTH:0]       add_w, sub_w, msum;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     sh_nxt, res_nxt;
    logic                 fin, c_nxt, o_nxt;

    assign BUSY = (state != IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        // top bit of the extended difference is the unsigned borrow
        sub_w   = {1'b0, a_q} - {1'b0, b_q};
        // multiplier bits sit in acc[WIDTH-1:0] and are consumed from the LSB
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        acc_nxt = {msum, acc[WIDTH-1:1]};
        case (sel_q)
            OP_SLL:  sh_nxt = {a_q[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_nxt = {1'b0, a_q[WIDTH-1:1]};
            OP_SRA:  sh_nxt = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: sh_nxt = {a_q[0], a_q[WIDTH-1:1]};
        endcase

        state_nxt = state;
        fin       = 1'b0;
        res_nxt   = RESULT;
        c_nxt     = 1'b0;
        o_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    if (SELECT == OP_MUL)                   state_nxt = MUL;
                    else if (SELECT inside {[OP_SLL:OP_ROR]}) state_nxt = SHIFT;
                    else                                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                fin       = 1'b1;
                state_nxt = IDLE;
                case (sel_q)
                    OP_FWD: res_nxt = b_q;
                    OP_ADD: begin
                        res_nxt = add_w[WIDTH-1:0];
                        c_nxt   = add_w[WIDTH];
                        o_nxt   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_AND: res_nxt = a_q & b_q;
                    OP_OR:  res_nxt = a_q | b_q;
                    OP_SUB: begin
                        res_nxt = sub_w[WIDTH-1:0];
                        c_nxt   = sub_w[WIDTH];
                        o_nxt   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    default: res_nxt = '0;
                endcase
            end
            MUL: begin
                if (cnt == SHW'(WIDTH-1)) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                    res_nxt   = acc_nxt[WIDTH-1:0];
                    o_nxt     = |acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
            SHIFT: begin
                // cnt holds the remaining shift count; zero means pass A straight through
                if (cnt == '0) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                    res_nxt   = a_q;
                end else if (cnt == SHW'(1)) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                    res_nxt   = sh_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RESULT <= '0;
            ZERO   <= 1'b0;
            CARRY  <= 1'b0;
            OVF    <= 1'b0;
            DONE   <= 1'b0;
            sel_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            DONE <= fin;
            if (fin) begin
                RESULT <= res_nxt;
                ZERO   <= (res_nxt == '0);
                CARRY  <= c_nxt;
                OVF    <= o_nxt;
            end
            case (state)
                IDLE: begin
                    if (START) begin
                        a_q   <= DATA1;
                        b_q   <= DATA2;
                        sel_q <= SELECT;
                        acc   <= {{WIDTH{1'b0}}, DATA2};
                        cnt   <= (SELECT == OP_MUL) ? '0 : DATA2[SHW-1:0];
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt + SHW'(1);
                end
                SHIFT: begin
                    a_q <= sh_nxt;
                    cnt <= cnt - SHW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
